// File: rtl/bf16_conv_writeback.sv
// bf16_conv_writeback: writeback buffer for BF16/FP32 conversion results.
// Each accepted result is normalised and then stored with its flags and destination tag
// in a circular FIFO. Entries are released to the register-file write port through a
// valid/ready interface.
//
// Handshake: an input transfer happens on a rising edge where in_valid && in_ready.
// An output transfer happens on a rising edge where out_valid && out_ready.
// in_ready depends only on the stored count. The output is never presented on the
// same cycle as the input, so there is no bypass path.
//
// Optional macro WB_FPCSR_STICKY_EN: when it is defined, the flags of every popped
// entry are ORed into sticky_fpcsr. When it is not defined, sticky_fpcsr is always
// zero and sticky_clr is ignored.
module bf16_conv_writeback #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [31:0]              in_result,
    input  logic [3:0]               in_fpcsr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAG_W-1:0]         out_tag,
    output logic [31:0]              out_result,
    output logic [3:0]               out_fpcsr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_pulse,
    output logic [3:0]               sticky_fpcsr,
    input  logic                     sticky_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_q, drop_d;

    logic [TAG_W-1:0] mem_tag_q    [DEPTH];
    logic [31:0]      mem_result_q [DEPTH];
    logic [3:0]       mem_fpcsr_q  [DEPTH];

    logic             push_hs;
    logic             op_legal;
    logic             store;
    logic             pop;
    logic [31:0]      norm_result;

    // Decode the handshakes and normalise the incoming result.
    always_comb begin
        op_legal    = (in_op == 4'd0) || (in_op == 4'd1);
        push_hs     = in_valid && in_ready;
        store       = push_hs && op_legal && !flush;
        pop         = out_valid && out_ready && !flush;
        norm_result = in_result;
        if (in_op == 4'd1) begin
            norm_result = {16'h0000, in_result[15:0]};
        end
    end

    assign in_ready   = (count_q < FULL_C);
    assign out_valid  = (count_q != '0);
    assign count      = count_q;
    assign drop_pulse = drop_q;

    // Show the head entry only while it is valid, so the outputs read zero after reset.
    always_comb begin
        out_tag    = '0;
        out_result = '0;
        out_fpcsr  = '0;
        if (out_valid) begin
            out_tag    = mem_tag_q[rd_ptr_q];
            out_result = mem_result_q[rd_ptr_q];
            out_fpcsr  = mem_fpcsr_q[rd_ptr_q];
        end
    end

    // Compute the next pointers, count and drop pulse. A flush overrides every handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            drop_d = push_hs && !op_legal;
            if (store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage. The contents do not need a reset because the read side is gated by count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_tag_q[wr_ptr_q]    <= in_tag;
            mem_result_q[wr_ptr_q] <= norm_result;
            mem_fpcsr_q[wr_ptr_q]  <= in_fpcsr;
        end
    end

`ifdef WB_FPCSR_STICKY_EN
    logic [3:0] sticky_q, sticky_d;

    // Clear first, then OR in the flags of the entry popped this cycle.
    always_comb begin
        sticky_d = sticky_clr ? 4'b0000 : sticky_q;
        if (pop) begin
            sticky_d = sticky_d | out_fpcsr;
        end
    end

    // Accumulated flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 4'b0000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_fpcsr = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_fpcsr      = 4'b0000;
`endif

endmodule

// File: tb/tb_bf16_conv_writeback.sv
// Testbench for bf16_conv_writeback. It uses directed vector tables, hand-written corner
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_bf16_conv_writeback;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
`ifdef WB_FPCSR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       in_op, in_fpcsr, out_fpcsr, sticky_fpcsr;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0]      in_result, out_result;
  logic [2:0]       count;
  logic             drop_pulse, sticky_clr;

  bf16_conv_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_result(in_result), .in_fpcsr(in_fpcsr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .out_fpcsr(out_fpcsr),
    .count(count), .drop_pulse(drop_pulse),
    .sticky_fpcsr(sticky_fpcsr), .sticky_clr(sticky_clr)
  );

  // ---------------- types ----------------
  typedef struct {
    logic             v;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [3:0]       f;
    logic             ordy;
    logic             fl;
    logic             clr;
    logic             rst;
  } stim_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [3:0]       f;
  } entry_t;

  typedef struct {
    stim_t            s;
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [31:0]      e_res;
    logic [3:0]       e_f;
    logic [2:0]       e_cnt;
    logic             e_drop;
  } vec_t;

  // ---------------- scoreboard / reference model ----------------
  entry_t     exp_q[$];
  logic       m_drop;
  logic [3:0] m_sticky;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t mk(input logic v, input logic [3:0] op, input logic [TAG_W-1:0] tag,
                               input logic [31:0] res, input logic [3:0] f, input logic ordy,
                               input logic fl, input logic clr, input logic rst);
    stim_t s;
    s.v = v; s.op = op; s.tag = tag; s.res = res; s.f = f;
    s.ordy = ordy; s.fl = fl; s.clr = clr; s.rst = rst;
    return s;
  endfunction

  function automatic stim_t idle(input logic ordy);
    return mk(1'b0, 4'd0, '0, 32'h0, 4'h0, ordy, 1'b0, 1'b0, 1'b0);
  endfunction

  // Compare every DUT output against the model state after the edge.
  task automatic check_model();
    check("m_count", {29'd0, count}, exp_q.size());
    check("m_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
    check("m_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check("m_drop", {31'd0, drop_pulse}, {31'd0, m_drop});
    check("m_sticky", {28'd0, sticky_fpcsr}, {28'd0, m_sticky});
    if (exp_q.size() != 0) begin
      check("m_out_tag", {{(32-TAG_W){1'b0}}, out_tag}, {{(32-TAG_W){1'b0}}, exp_q[0].tag});
      check("m_out_result", out_result, exp_q[0].res);
      check("m_out_fpcsr", {28'd0, out_fpcsr}, {28'd0, exp_q[0].f});
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input stim_t s);
    entry_t it;
    bit     m_rdy, m_vld;
    reset = s.rst; flush = s.fl; in_valid = s.v; in_op = s.op; in_tag = s.tag;
    in_result = s.res; in_fpcsr = s.f; out_ready = s.ordy; sticky_clr = s.clr;
    m_rdy = exp_q.size() < DEPTH;
    m_vld = exp_q.size() != 0;
    if (s.rst) begin
      exp_q.delete();
      m_drop   = 1'b0;
      m_sticky = 4'h0;
    end else begin
      m_drop = 1'b0;
      if (STICKY && s.clr) m_sticky = 4'h0;
      if (s.fl) begin
        exp_q.delete();
      end else begin
        if (m_vld && s.ordy) begin
          it = exp_q.pop_front();
          if (STICKY) m_sticky = m_sticky | it.f;
        end
        if (s.v && m_rdy) begin
          it.tag = s.tag; it.f = s.f;
          if (s.op == 4'd0) begin
            it.res = s.res;
            exp_q.push_back(it);
          end else if (s.op == 4'd1) begin
            it.res = {16'h0000, s.res[15:0]};
            exp_q.push_back(it);
          end else begin
            m_drop = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    cycle(mk(1'b0, 4'd0, '0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push(input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic [31:0] res,
                      input logic [3:0] f);
    cycle(mk(1'b1, op, tag, res, f, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // ---------------- test ----------------
  vec_t vec[11];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
    in_result = '0; in_fpcsr = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    exp_q.delete(); m_drop = 1'b0; m_sticky = 4'h0;

    // Directed vector table: {stimulus, expected outputs after the edge}.
    vec[0]  = '{mk(1,0,3,32'h3F80_0000,4'h0,0,0,0,0), 1, 3, 32'h3F80_0000, 4'h0, 3'd1, 0};
    vec[1]  = '{idle(0),                             1, 3, 32'h3F80_0000, 4'h0, 3'd1, 0};
    vec[2]  = '{idle(0),                             1, 3, 32'h3F80_0000, 4'h0, 3'd1, 0};
    vec[3]  = '{idle(0),                             1, 3, 32'h3F80_0000, 4'h0, 3'd1, 0};
    vec[4]  = '{mk(1,1,9,32'hDEAD_3FC0,4'h2,0,0,0,0), 1, 3, 32'h3F80_0000, 4'h0, 3'd2, 0};
    vec[5]  = '{idle(1),                             1, 9, 32'h0000_3FC0, 4'h2, 3'd1, 0};
    vec[6]  = '{idle(1),                             0, 0, 32'h0,         4'h0, 3'd0, 0};
    vec[7]  = '{mk(1,5,7,32'h1234_5678,4'h0,0,0,0,0), 0, 0, 32'h0,         4'h0, 3'd0, 1};
    vec[8]  = '{idle(0),                             0, 0, 32'h0,         4'h0, 3'd0, 0};
    vec[9]  = '{mk(1,0,11,32'hAAAA_5555,4'h3,1,0,0,0), 1, 11, 32'hAAAA_5555, 4'h3, 3'd1, 0};
    vec[10] = '{idle(1),                             0, 0, 32'h0,         4'h0, 3'd0, 0};

    do_reset();
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_fpcsr", {28'd0, out_fpcsr}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      cycle(vec[i].s);
      check("tbl_valid", {31'd0, out_valid}, {31'd0, vec[i].e_valid});
      check("tbl_count", {29'd0, count}, {29'd0, vec[i].e_cnt});
      check("tbl_drop", {31'd0, drop_pulse}, {31'd0, vec[i].e_drop});
      if (vec[i].e_valid) begin
        check("tbl_tag", {27'd0, out_tag}, {27'd0, vec[i].e_tag});
        check("tbl_result", out_result, vec[i].e_res);
        check("tbl_fpcsr", {28'd0, out_fpcsr}, {28'd0, vec[i].e_f});
      end
    end

    // Fill and drain three times so the pointers wrap. Also check that no push is accepted when full.
    for (int r = 0; r < 3; r++) begin
      for (int t = 1; t <= 4; t++) push(4'd0, TAG_W'(r * 8 + t), 32'h100 * t, 4'h0);
      check("full_count", {29'd0, count}, 32'd4);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_head", {27'd0, out_tag}, r * 8 + 1);
      cycle(mk(1, 0, TAG_W'(r * 8 + 5), 32'h500, 4'h0, 1, 0, 0, 0));
      check("full_pop_count", {29'd0, count}, 32'd3);
      for (int t = 2; t <= 4; t++) begin
        check("drain_tag", {27'd0, out_tag}, r * 8 + t);
        cycle(idle(1));
      end
      check("drain_empty", {31'd0, out_valid}, 32'd0);
    end

    // A flush overrides a simultaneous push and pop. An illegal op during a flush produces no drop pulse.
    push(4'd0, 5'd1, 32'h1, 4'h0);
    push(4'd1, 5'd2, 32'h2, 4'h0);
    cycle(mk(1, 0, 20, 32'h20, 4'h0, 1, 1, 0, 0));
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(idle(0));
    check("flush_no_accept", {29'd0, count}, 32'd0);
    cycle(mk(1, 6, 21, 32'h21, 4'h0, 0, 1, 0, 0));
    check("flush_no_drop", {31'd0, drop_pulse}, 32'd0);

    // Reset in the middle of a stream.
    for (int t = 1; t <= 3; t++) push(4'd0, TAG_W'(t), 32'hF0 + t, 4'hF);
    do_reset();
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_tag", {27'd0, out_tag}, 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_fpcsr", {28'd0, out_fpcsr}, 32'd0);

    // Sticky flag accumulation, then a clear on the same cycle as a pop.
    push(4'd0, 5'd1, 32'h1, 4'b0001);
    push(4'd0, 5'd2, 32'h2, 4'b0100);
    cycle(idle(1));
    cycle(idle(1));
    check("sticky_or", {28'd0, sticky_fpcsr}, STICKY ? 32'h5 : 32'h0);
    push(4'd0, 5'd3, 32'h3, 4'b1000);
    cycle(mk(0, 0, 0, 32'h0, 4'h0, 1, 0, 1, 0));
    check("sticky_clr_pop", {28'd0, sticky_fpcsr}, STICKY ? 32'h8 : 32'h0);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      stim_t s;
      s.v    = ($urandom_range(0, 3) != 0);
      s.op   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
      s.tag  = TAG_W'($urandom);
      s.res  = $urandom;
      s.f    = 4'($urandom);
      s.ordy = ($urandom_range(0, 2) != 0);
      s.fl   = ($urandom_range(0, 39) == 0);
      s.clr  = ($urandom_range(0, 15) == 0);
      s.rst  = ($urandom_range(0, 199) == 0);
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
